bulls_cows_engine: RTL and testbench

//   Parametrised two-player Bulls & Cows game core: generalised in digit count and digit width.

---
 rtl/bulls_cows_engine_if.sv | 32 +++
 rtl/bulls_cows_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_bulls_cows_engine.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bulls_cows_engine_if.sv
// Player-facing bus of the Bulls & Cows core: guess/confirm entry plus scoring/status outputs.
interface bulls_cows_engine_if #(
    parameter int N_DIGITS = 4,
    parameter int DIGIT_W  = 4,
    parameter int ROUND_W  = 8
);
    localparam int BC_W = $clog2(N_DIGITS + 1);

    logic [N_DIGITS*DIGIT_W-1:0] guess;
    logic                        confirm;
    logic [2:0]                  state;
    logic                        player;
    logic [BC_W-1:0]             bulls;
    logic [BC_W-1:0]             cows;
    logic                        result_valid;
    logic                        win_flag;
    logic                        winner;
    logic [ROUND_W-1:0]          round_count;
    logic                        err_invalid;

    modport master (
        output guess, confirm,
        input  state, player, bulls, cows, result_valid, win_flag, winner,
               round_count, err_invalid
    );

    modport slave (
        input  guess, confirm,
        output state, player, bulls, cows, result_valid, win_flag, winner,
               round_count, err_invalid
    );
endinterface

// File: rtl/bulls_cows_engine.sv
// Two-player Bulls & Cows core, scoring one digit per clock.
// Optional entry validation (digits 0..9, all distinct) enabled by `define BULLS_COWS_VALIDATE_EN.
module bulls_cows_engine #(
    parameter int N_DIGITS   = 4,
    parameter int DIGIT_W    = 4,
    parameter int MAX_ROUNDS = 0,
    parameter int ROUND_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    bulls_cows_engine_if.slave bus
);
    localparam int BC_W  = $clog2(N_DIGITS + 1);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int GW    = N_DIGITS * DIGIT_W;

    typedef enum logic [2:0] {
        S_SECRET1 = 3'd0,
        S_SECRET2 = 3'd1,
        S_GUESS   = 3'd2,
        S_SCORE   = 3'd3,
        S_RESULT  = 3'd4,
        S_WIN     = 3'd5,
        S_DRAW    = 3'd6
    } state_t;

    state_t             state_reg, state_next;
    logic               player_reg, player_next;
    logic [BC_W-1:0]    bulls_reg, bulls_next;
    logic [BC_W-1:0]    cows_reg, cows_next;
    logic               result_valid_reg, result_valid_next;
    logic               winner_reg, winner_next;
    logic [ROUND_W-1:0] round_reg, round_next;
    logic               err_reg, err_next;
    logic [GW-1:0]      secret_p1_reg, secret_p1_next;
    logic [GW-1:0]      secret_p2_reg, secret_p2_next;
    logic [GW-1:0]      guess_reg, guess_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               confirm_reg;

    logic               confirm_edge;
    logic               entry_ok;
    logic [GW-1:0]      secret_opp;
    logic [DIGIT_W-1:0] g_d [N_DIGITS];
    logic [DIGIT_W-1:0] s_d [N_DIGITS];
    logic [DIGIT_W-1:0] g_cur, s_cur;
    logic [N_DIGITS-1:0] cow_hit;
    logic               bull_hit, cow_inc;
    logic [BC_W-1:0]    bulls_sum;
    logic [ROUND_W-1:0] round_inc;

    assign confirm_edge = bus.confirm & ~confirm_reg;
    // Player 0 guesses against player 1's secret, which is stored as secret_p2.
    assign secret_opp   = player_reg ? secret_p1_reg : secret_p2_reg;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digits
            assign g_d[gi]     = guess_reg[gi*DIGIT_W +: DIGIT_W];
            assign s_d[gi]     = secret_opp[gi*DIGIT_W +: DIGIT_W];
            assign cow_hit[gi] = (s_d[gi] == g_cur) && (idx_reg != IDX_W'(gi));
        end
    endgenerate

    assign g_cur     = g_d[idx_reg];
    assign s_cur     = s_d[idx_reg];
    assign bull_hit  = (g_cur == s_cur);
    assign cow_inc   = ~bull_hit & (|cow_hit);
    assign bulls_sum = bulls_reg + BC_W'(bull_hit);
    assign round_inc = (round_reg == {ROUND_W{1'b1}}) ? round_reg : round_reg + 1'b1;

`ifdef BULLS_COWS_VALIDATE_EN
    logic [DIGIT_W-1:0]  in_d [N_DIGITS];
    logic [N_DIGITS-1:0] digit_ok;
    logic                dup_found;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_valid
            assign in_d[gi]     = bus.guess[gi*DIGIT_W +: DIGIT_W];
            assign digit_ok[gi] = (32'(in_d[gi]) <= 32'd9);
        end
    endgenerate

    always_comb begin
        dup_found = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            for (int j = i + 1; j < N_DIGITS; j++) begin
                if (in_d[i] == in_d[j]) dup_found = 1'b1;
            end
        end
    end

    assign entry_ok = (&digit_ok) & ~dup_found;
`else
    assign entry_ok = 1'b1;
`endif

    always_comb begin
        state_next        = state_reg;
        player_next       = player_reg;
        bulls_next        = bulls_reg;
        cows_next         = cows_reg;
        result_valid_next = 1'b0;
        winner_next       = winner_reg;
        round_next        = round_reg;
        err_next          = 1'b0;
        secret_p1_next    = secret_p1_reg;
        secret_p2_next    = secret_p2_reg;
        guess_next        = guess_reg;
        idx_next          = idx_reg;
        case (state_reg)
            S_SECRET1: if (confirm_edge) begin
                if (entry_ok) begin
                    secret_p1_next = bus.guess;
                    state_next     = S_SECRET2;
                end else begin
                    err_next = 1'b1;
                end
            end
            S_SECRET2: if (confirm_edge) begin
                if (entry_ok) begin
                    secret_p2_next = bus.guess;
                    player_next    = 1'b0;
                    state_next     = S_GUESS;
                end else begin
                    err_next = 1'b1;
                end
            end
            S_GUESS: if (confirm_edge) begin
                if (entry_ok) begin
                    guess_next = bus.guess;
                    bulls_next = '0;
                    cows_next  = '0;
                    idx_next   = '0;
                    state_next = S_SCORE;
                end else begin
                    err_next = 1'b1;
                end
            end
            S_SCORE: begin
                bulls_next = bulls_sum;
                cows_next  = cows_reg + BC_W'(cow_inc);
                if (idx_reg == IDX_W'(N_DIGITS - 1)) begin
                    result_valid_next = 1'b1;
                    if (bulls_sum == BC_W'(N_DIGITS)) begin
                        state_next  = S_WIN;
                        winner_next = player_reg;
                    end else begin
                        state_next = S_RESULT;
                    end
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            S_RESULT: if (confirm_edge) begin
                // A full round closes when player 1 finishes its guess.
                if (player_reg) round_next = round_inc;
                if (player_reg && (MAX_ROUNDS != 0) && (32'(round_inc) == 32'(MAX_ROUNDS))) begin
                    state_next = S_DRAW;
                end else begin
                    player_next = ~player_reg;
                    state_next  = S_GUESS;
                end
            end
            S_WIN, S_DRAW: if (confirm_edge) begin
                state_next     = S_SECRET1;
                player_next    = 1'b0;
                bulls_next     = '0;
                cows_next      = '0;
                winner_next    = 1'b0;
                round_next     = '0;
                secret_p1_next = '0;
                secret_p2_next = '0;
                guess_next     = '0;
                idx_next       = '0;
            end
            default: state_next = S_SECRET1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= S_SECRET1;
            player_reg       <= 1'b0;
            bulls_reg        <= '0;
            cows_reg         <= '0;
            result_valid_reg <= 1'b0;
            winner_reg       <= 1'b0;
            round_reg        <= '0;
            err_reg          <= 1'b0;
            secret_p1_reg    <= '0;
            secret_p2_reg    <= '0;
            guess_reg        <= '0;
            idx_reg          <= '0;
            confirm_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            player_reg       <= player_next;
            bulls_reg        <= bulls_next;
            cows_reg         <= cows_next;
            result_valid_reg <= result_valid_next;
            winner_reg       <= winner_next;
            round_reg        <= round_next;
            err_reg          <= err_next;
            secret_p1_reg    <= secret_p1_next;
            secret_p2_reg    <= secret_p2_next;
            guess_reg        <= guess_next;
            idx_reg          <= idx_next;
            confirm_reg      <= bus.confirm;
        end
    end

    assign bus.state        = state_reg;
    assign bus.player       = player_reg;
    assign bus.bulls        = bulls_reg;
    assign bus.cows         = cows_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.win_flag     = (state_reg == S_WIN);
    assign bus.winner       = winner_reg;
    assign bus.round_count  = round_reg;
    assign bus.err_invalid  = err_reg;
endmodule

// File: tb/tb_bulls_cows_engine.sv
// Directed bench for bulls_cows_engine (N_DIGITS=4, DIGIT_W=4, MAX_ROUNDS=2).
module tb_bulls_cows_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bulls_cows_engine_if #(.N_DIGITS(4), .DIGIT_W(4), .ROUND_W(8)) bus ();

    bulls_cows_engine #(
        .N_DIGITS(4), .DIGIT_W(4), .MAX_ROUNDS(2), .ROUND_W(8)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] g;
        int bulls;
        int cows;
        int st;
        int st_after;
        int player_after;
        int round_after;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // digit0 is the first listed digit, stored in the low nibble
    function automatic logic [15:0] pk(input int d0, input int d1, input int d2, input int d3);
        return {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
    endfunction

    task automatic press(input logic [15:0] g);
        bus.guess   = g;
        bus.confirm = 1'b1;
        @(negedge clk);
        bus.confirm = 1'b0;
        @(negedge clk);
        $display("press guess=%h -> state=%0d player=%0d round=%0d",
                 g, bus.state, bus.player, bus.round_count);
    endtask

    // Confirms a guess and returns the number of cycles until result_valid (0 = timeout).
    task automatic do_guess(input logic [15:0] g, output int lat);
        bus.guess   = g;
        bus.confirm = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.confirm = 1'b0;
            if (bus.result_valid) begin
                lat = k;
                break;
            end
        end
        $display("guess=%h lat=%0d bulls=%0d cows=%0d state=%0d",
                 g, lat, bus.bulls, bus.cows, bus.state);
    endtask

    task automatic load_secrets();
        press(pk(1, 2, 3, 4));
        chk("secret1_taken", bus.state, 1);
        press(pk(5, 6, 7, 8));
        chk("secret2_taken", bus.state, 2);
        chk("secret2_player", bus.player, 0);
    endtask

    initial begin
        int lat;
        int pulses;
        bus.guess   = '0;
        bus.confirm = 1'b0;

        vecs[0] = '{pk(5, 6, 8, 7), 2, 2, 4, 2, 1, 0};
        vecs[1] = '{pk(4, 3, 2, 1), 0, 4, 4, 2, 0, 1};
        vecs[2] = '{pk(9, 0, 1, 2), 0, 0, 4, 2, 1, 1};
        vecs[3] = '{pk(1, 2, 9, 0), 2, 0, 4, 6, 1, 2};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", bus.state, 0);
        chk("rst_player", bus.player, 0);
        chk("rst_bulls", bus.bulls, 0);
        chk("rst_cows", bus.cows, 0);
        chk("rst_valid", bus.result_valid, 0);
        chk("rst_win", bus.win_flag, 0);
        chk("rst_winner", bus.winner, 0);
        chk("rst_round", bus.round_count, 0);
        chk("rst_err", bus.err_invalid, 0);

        // Game A: four non-winning guesses run into the round limit
        load_secrets();
        for (int i = 0; i < 4; i++) begin
            do_guess(vecs[i].g, lat);
            chk($sformatf("v%0d_latency", i), lat, 5);
            chk($sformatf("v%0d_bulls", i), bus.bulls, vecs[i].bulls);
            chk($sformatf("v%0d_cows", i), bus.cows, vecs[i].cows);
            chk($sformatf("v%0d_state", i), bus.state, vecs[i].st);
            press('0);
            chk($sformatf("v%0d_state_after", i), bus.state, vecs[i].st_after);
            chk($sformatf("v%0d_player_after", i), bus.player, vecs[i].player_after);
            chk($sformatf("v%0d_round_after", i), bus.round_count, vecs[i].round_after);
        end
        press('0);
        chk("draw_exit_state", bus.state, 0);
        chk("draw_exit_round", bus.round_count, 0);

        // Game B: held confirm gives one scoring pass, then P1 wins
        load_secrets();
        bus.guess   = pk(5, 6, 8, 7);
        bus.confirm = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 50) bus.confirm = 1'b0;
            if (bus.result_valid) pulses++;
        end
        $display("held confirm: pulses=%0d state=%0d", pulses, bus.state);
        chk("held_pulses", pulses, 1);
        chk("held_state", bus.state, 4);
        chk("held_bulls", bus.bulls, 2);
        chk("held_cows", bus.cows, 2);
        press('0);
        chk("b_player1", bus.player, 1);
        do_guess(pk(4, 3, 2, 1), lat);
        chk("b_p2_cows", bus.cows, 4);
        press('0);
        chk("b_round1", bus.round_count, 1);
        do_guess(pk(5, 6, 7, 8), lat);
        chk("win_latency", lat, 5);
        chk("win_bulls", bus.bulls, 4);
        chk("win_cows", bus.cows, 0);
        chk("win_state", bus.state, 5);
        chk("win_flag", bus.win_flag, 1);
        chk("win_winner", bus.winner, 0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        chk("win_hold_state", bus.state, 5);
        chk("win_hold_bulls", bus.bulls, 4);
        chk("win_hold_pulses", pulses, 0);
        press(pk(5, 6, 7, 8));
        chk("win_exit_state", bus.state, 0);
        chk("win_exit_flag", bus.win_flag, 0);
        chk("win_exit_bulls", bus.bulls, 0);

        // Game C: player 2 wins
        load_secrets();
        do_guess(pk(1, 2, 3, 4), lat);
        chk("c_p1_bulls", bus.bulls, 0);
        press('0);
        do_guess(pk(1, 2, 3, 4), lat);
        chk("c_win_state", bus.state, 5);
        chk("c_winner", bus.winner, 1);
        press('0);
        chk("c_exit_winner", bus.winner, 0);

        // Reset on the second SCORE cycle aborts scoring
        load_secrets();
        bus.guess   = pk(5, 6, 8, 7);
        bus.confirm = 1'b1;
        @(negedge clk);
        bus.confirm = 1'b0;
        chk("abort_in_score", bus.state, 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_state", bus.state, 0);
        chk("abort_bulls", bus.bulls, 0);
        chk("abort_cows", bus.cows, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        $display("abort: pulses=%0d state=%0d", pulses, bus.state);
        chk("abort_no_valid", pulses, 0);
        chk("abort_idle_state", bus.state, 0);

        // Entry validation
        bus.guess   = pk(1, 1, 2, 3);
        bus.confirm = 1'b1;
        @(negedge clk);
        bus.confirm = 1'b0;
`ifdef BULLS_COWS_VALIDATE_EN
        chk("dup_err", bus.err_invalid, 1);
        chk("dup_state", bus.state, 0);
`else
        chk("dup_err", bus.err_invalid, 0);
        chk("dup_state", bus.state, 1);
`endif
        @(negedge clk);
        chk("dup_err_pulse", bus.err_invalid, 0);
        bus.guess   = pk(1, 2, 10, 4);
        bus.confirm = 1'b1;
        @(negedge clk);
        bus.confirm = 1'b0;
`ifdef BULLS_COWS_VALIDATE_EN
        chk("hex_err", bus.err_invalid, 1);
        chk("hex_state", bus.state, 0);
`else
        chk("hex_err", bus.err_invalid, 0);
        chk("hex_state", bus.state, 2);
`endif
        @(negedge clk);
        $display("validation done: state=%0d err=%0d", bus.state, bus.err_invalid);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
